dmem_arbiter: RTL
=================

# dmem_arbiter

Shares a single synchronous data-memory port between the two pipelined cores. Each core's Memory stage issues load/store requests. The block grants one request at a time with round-robin priority and stalls the losing or waiting core. It sequences each read across the fixed memory read latency and returns the read data to the Memory stage at the cycle that core's stall is released.

## Interface
Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- LAT, 1: memory read latency in cycles, counted from issue to `mem_rdata` valid. Legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; asynchronous, active-high.
- req0 / req1  in  1  core N's Memory stage holds a load or store.
- we0 / we1  in  1  1 = store, 0 = load. Must be stable while reqN is high.
- addr0 / addr1  in  ADDR_W  word address. Must be stable while reqN is high.
- wdata0 / wdata1  in  DATA_W  store data.
- stall0 / stall1  out  1  hold core N's pipeline (F/D/E/M registers).
- rdata0 / rdata1  out  DATA_W  load data returned to core N's Memory stage.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data. Valid LAT cycles after a read issue.
- busy  out  1  a read is in flight (state WAIT).

## Operation
States:
- IDLE: no read in flight.
- WAIT: read in flight. The 3-bit counter `cnt` tracks elapsed cycles.

Registers:
- `last`: ID of the last granted core. Reset value 1, so core 0 wins the first tie.
- `owner`: ID of the core whose read is in flight.
- `rbuf0`, `rbuf1`: held read data per core.

Arbitration, in IDLE only:
- Only one core requesting: that core wins.
- Both cores requesting: the core ≠ `last` wins.
- On a grant, `last` takes the winner's ID.

Issue cycle, in IDLE with a winner:
- Drive `mem_en` = 1, plus `mem_we`, `mem_addr` and `mem_wdata` from the winner. These outputs are combinational.

Store grant:
- The store completes in the issue cycle.
- The winner's stall is 0 that cycle.
- The state stays IDLE.

Load grant:
- Next state is WAIT, with `cnt` = 1 and `owner` = winner.
- The winner's stall is 1.

WAIT:
- `mem_en` = 0.
- `cnt` increments each cycle.
- Completion cycle is `cnt` == LAT:
  - `rdata[owner]` = `mem_rdata` (combinational bypass).
  - `rbuf[owner]` ← `mem_rdata`.
  - `stall[owner]` = 0.
  - Next state is IDLE.
- Requests from the other core wait and are not issued during WAIT.

Outputs outside completion:
- `rdataN` = `rbufN`.
- `stallN` = `reqN` AND NOT (core N completes this cycle).

Boundary conditions:
- Request withdrawal during WAIT (e.g. a flushed core): the transaction still completes and `rbuf` is updated. The stall value is irrelevant once `req` is low.
- Both cores request while in WAIT: arbitration is evaluated in the first IDLE cycle after completion, with `last` = previous owner, so the other core wins.
- `cnt` never exceeds LAT.

Reset (asynchronous, any state, including mid-WAIT):
- State → IDLE, `cnt` = 0, `last` = 1, `owner` = 0, `rbuf0` = `rbuf1` = 0.
- While reset is high, `mem_en`, `mem_we`, `stall0`, `stall1` and `busy` are forced to 0, and `mem_addr`, `mem_wdata`, `rdata0` and `rdata1` read 0.
- An in-flight read is abandoned and its data is never delivered.

## Timing
- Store latency: 0 cycles. A store is issued and released in the same cycle; back-to-back stores sustain 1 per cycle per arbiter.
- Load latency: issue at cycle T, data and stall release at T+LAT. The next issue can occur at T+LAT+1, so the minimum load period is LAT+1 cycles.
- Contention: a losing core stalls at least 1 cycle. If the winner issues a load, the loser stalls LAT+1 cycles before its own issue.
- Fairness: with continuous requests from both cores, grants alternate strictly 0,1,0,1…
- `busy` is high exactly in WAIT cycles.
- No combinational path from `mem_rdata` to `mem_*` outputs. The only `mem_rdata` path runs to `rdataN`.

## Test plan
- Reset then single store: req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF at cycle 0 → `mem_en`=1, `mem_we`=1, `mem_addr`=0x10 in cycle 0; `stall0`=0; `busy` stays 0.
- Single load, LAT=1: req1=1, we1=0, addr1=0x20, memory returns 0x1234 → cycle 0: `mem_en`=1, `stall1`=1. Cycle 1: `stall1`=0, `rdata1`=0x1234, `busy`=1. Cycle 2: IDLE, `rdata1` holds 0x1234.
- Tie after reset: both cores issue a store in the same cycle → core 0 granted cycle 0 with `stall1`=1; core 1 granted cycle 1. Repeat with continuous requests → grant order 0,1,0,1.
- Load blocking a store, LAT=3: core 0 loads and core 1 stores simultaneously → core 0 issues at T, `stall1`=1 for T..T+3, core 0 released at T+3, core 1 store issued at T+4.
- Flush mid-read: req0 dropped at T+1 of a LAT=2 load → completion still at T+2, `rbuf0` updated, next request served at T+3.
- Async reset at T+1 of a LAT=3 load → all outputs 0 immediately; after release, state is IDLE, `busy`=0, `rdata0`=0, and core 0 wins the next tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one synchronous data-memory port between two pipelined cores.
// Requests are granted one at a time with round-robin priority. Stores
// complete in their issue cycle. Loads are held across the fixed memory read
// latency LAT, and the data is returned in the cycle the owning core's stall
// is released.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req0/1, we0/1           core request and store(1)/load(0) select
//   addr0/1, wdata0/1       core word address and store data
//   stall0/1                hold core N's pipeline
//   rdata0/1                load data returned to core N
//   mem_en, mem_we          memory strobe and write enable (combinational)
//   mem_addr, mem_wdata     memory address and write data (combinational)
//   mem_rdata               memory read data, valid LAT cycles after issue
//   busy                    a read is in flight
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              stall0,
  output logic              stall1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic              last;
  logic              owner;
  logic [DATA_W-1:0] rbuf [2];

  // Per-core views of the request ports so the per-core logic can be indexed.
  logic [1:0]        reqV;
  logic [1:0]        weV;
  logic [ADDR_W-1:0] addrV  [2];
  logic [DATA_W-1:0] wdataV [2];
  logic [1:0]        stallV;
  logic [DATA_W-1:0] rdataV [2];

  assign reqV      = {req1, req0};
  assign weV       = {we1, we0};
  assign addrV[0]  = addr0;
  assign addrV[1]  = addr1;
  assign wdataV[0] = wdata0;
  assign wdataV[1] = wdata1;

  // Round-robin: on a tie the core that was not granted last wins. With a
  // single requester, winner simply follows req1.
  logic winner;
  logic issue;
  logic issueWe;
  logic storeDone;
  logic readDone;

  assign winner    = (req0 && req1) ? ~last : req1;
  assign issue     = (state == IDLE) && (req0 || req1);
  assign issueWe   = weV[winner];
  assign storeDone = issue && issueWe;
  assign readDone  = (state == WAIT) && (cnt == 3'(LAT));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gCore
      logic completes;
      logic ownsRead;
      assign ownsRead   = readDone && (owner == 1'(gi));
      assign completes  = (storeDone && (winner == 1'(gi))) || ownsRead;
      assign stallV[gi] = !reset && reqV[gi] && !completes;
      // Read data bypasses straight from memory in the completion cycle so
      // the core sees it the same cycle its stall drops.
      assign rdataV[gi] = reset    ? '0 :
                          ownsRead ? mem_rdata : rbuf[gi];
    end
  endgenerate

  assign stall0 = stallV[0];
  assign stall1 = stallV[1];
  assign rdata0 = rdataV[0];
  assign rdata1 = rdataV[1];

  // Memory side is driven only from request inputs and state, never from
  // mem_rdata.
  assign mem_en    = !reset && issue;
  assign mem_we    = !reset && issue && issueWe;
  assign mem_addr  = (!reset && issue) ? addrV[winner]  : '0;
  assign mem_wdata = (!reset && issue) ? wdataV[winner] : '0;
  assign busy      = !reset && (state == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      last    <= 1'b1;
      owner   <= 1'b0;
      rbuf[0] <= '0;
      rbuf[1] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            last <= winner;
            if (!issueWe) begin
              state <= WAIT;
              cnt   <= 3'd1;
              owner <= winner;
            end
          end
        end
        WAIT: begin
          // The read completes even if the owner has withdrawn its request.
          if (readDone) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            rbuf[owner] <= mem_rdata;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule
